// File: rtl/pool_window_gen.sv
// -----------------------------------------------------------------------------
// pool_window_gen
//   Turns a raster-order pixel stream into non-overlapping 2x2 windows for a
//   downstream max-pooling stage. Even rows are parked in a one-row line
//   buffer. On odd rows the left pixel of each pair is held in a register.
//   The right pixel of the pair completes a window, which is launched from a
//   single output register.
//
// Parameters
//   DATA_WIDTH  signed pixel width
//   IMG_WIDTH   pixels per row (even, >= 2)
//   IMG_HEIGHT  rows per frame (even, >= 2)
//   POOL_SIZE   window elements (2x2 only)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   pix_valid  input pixel valid
//   pix_ready  block can accept a pixel this cycle
//   pix_data   signed pixel, row-major raster order
//   win_valid  window valid
//   win_ready  downstream accepts window
//   win_data   [0]=top-left [1]=top-right [2]=bottom-left [3]=bottom-right
//   win_last   final window of the frame (qualified by win_valid)
// -----------------------------------------------------------------------------
module pool_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int POOL_SIZE  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic signed [DATA_WIDTH-1:0] pix_data,
  output logic                         win_valid,
  input  logic                         win_ready,
  output logic signed [DATA_WIDTH-1:0] win_data [POOL_SIZE],
  output logic                         win_last
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  typedef enum logic {FILL = 1'b0, PAIR = 1'b1} state_t;

  state_t                         state, state_nxt;
  logic        [COL_W-1:0]        col;
  logic        [ROW_W-1:0]        row;
  logic signed [DATA_WIDTH-1:0]   lb [IMG_WIDTH];
  logic signed [DATA_WIDTH-1:0]   left_p0;
  logic signed [DATA_WIDTH-1:0]   win_data_p1 [POOL_SIZE];
  logic                           vld_p1;
  logic                           last_p1;

  logic accept, col_last, row_last;
  logic lb_we, left_we, win_load;

  assign pix_ready = !vld_p1 || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign col_last  = (col == COL_W'(IMG_WIDTH - 1));
  assign row_last  = (row == ROW_W'(IMG_HEIGHT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next state: one full row in each state
  always_comb begin
    state_nxt = state;
    if (accept && col_last) begin
      case (state)
        FILL:    state_nxt = PAIR;
        PAIR:    state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  // Datapath controls decoded from state and column parity
  always_comb begin
    lb_we    = 1'b0;
    left_we  = 1'b0;
    win_load = 1'b0;
    if (accept) begin
      case (state)
        FILL:    lb_we = 1'b1;
        PAIR: begin
          left_we  = !col[0];
          win_load =  col[0];
        end
        default: lb_we = 1'b0;
      endcase
    end
  end

  // Raster position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Line buffer holds the even row. It is always rewritten before the odd row
  // reads it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (lb_we) lb[col] <= pix_data;
  end

  // Stage p0: left pixel of the current odd-row pair
  always_ff @(posedge clk) begin
    if (rst)          left_p0 <= '0;
    else if (left_we) left_p0 <= pix_data;
  end

  // Stage p1: output window register. A load takes priority over a transfer,
  // so a transfer and a new window in the same cycle keep valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      for (int i = 0; i < POOL_SIZE; i++) win_data_p1[i] <= '0;
    end else if (win_load) begin
      vld_p1         <= 1'b1;
      last_p1        <= row_last && col_last;
      win_data_p1[0] <= lb[col - COL_W'(1)];
      win_data_p1[1] <= lb[col];
      win_data_p1[2] <= left_p0;
      win_data_p1[3] <= pix_data;
    end else if (win_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign win_valid = vld_p1;
  assign win_last  = last_p1;
  assign win_data  = win_data_p1;

endmodule

// File: tb/tb_pool_window_gen.sv
module tb_pool_window_gen;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 4x4 instance
  logic                 pix_valid, pix_ready, win_valid, win_ready, win_last;
  logic signed [DW-1:0] pix_data;
  logic signed [DW-1:0] win_data [4];

  // 2x2 instance
  logic                 pv2, pr2, wv2, wr2, wl2;
  logic signed [DW-1:0] pd2;
  logic signed [DW-1:0] wd2 [4];

  pool_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4), .POOL_SIZE(4)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .win_valid(win_valid), .win_ready(win_ready),
    .win_data(win_data), .win_last(win_last));

  pool_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(2), .IMG_HEIGHT(2), .POOL_SIZE(4)) dut2 (
    .clk(clk), .rst(rst), .pix_valid(pv2), .pix_ready(pr2),
    .pix_data(pd2), .win_valid(wv2), .win_ready(wr2),
    .win_data(wd2), .win_last(wl2));

  typedef struct packed {
    logic [31:0] d;
    logic        last;
    logic [31:0] cyc;
  } exp_t;

  exp_t q4[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  bit   seen = 1'b0;

  // Hand-computed windows {tl,tr,bl,br}
  logic [31:0] exp_a [4] = '{32'h00010405, 32'h02030607, 32'h08090C0D, 32'h0A0B0E0F};
  logic [31:0] exp_b [4] = '{32'h64656869, 32'h66676A6B, 32'h6C6D7071, 32'h6E6F7273};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares the presented window with the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && win_valid) begin
        if (q4.size() == 0) begin
          chk("spurious_window", {32'h0, win_data[0], win_data[1], win_data[2], win_data[3]}, 64'h0);
        end else begin
          if (!seen) begin
            chk("latency", 64'(cyc), 64'(q4[0].cyc));
            seen = 1'b1;
          end
          chk("win_data", {32'h0, win_data[0], win_data[1], win_data[2], win_data[3]}, {32'h0, q4[0].d});
          chk("win_last", 64'(win_last), 64'(q4[0].last));
          if (!win_ready) chk("pix_ready_held", 64'(pix_ready), 64'h0);
          if (win_ready) begin
            void'(q4.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Present one pixel and wait (bounded) until it is accepted.
  task automatic put_px(input logic signed [DW-1:0] v, output int acc_cyc, output int waits);
    waits = 0;
    acc_cyc = 0;
    pix_valid = 1'b1;
    pix_data  = v;
    forever begin
      @(negedge clk);
      if (pix_ready) begin
        acc_cyc = cyc;
        break;
      end
      waits++;
      if (waits > 50) begin
        chk("accept_timeout", 64'(waits), 64'h0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame4(input int base, input logic [31:0] ew [4], input bit rnd_gap);
    int k = 0;
    int ac, w;
    for (int i = 0; i < 16; i++) begin
      if (rnd_gap && ($urandom_range(0, 1) == 1)) begin
        pix_valid = 1'b0;
        pix_data  = 8'h5A;
        @(posedge clk); #1;
      end
      put_px(DW'(base + i), ac, w);
      stall_cnt += w;
      if (i == 5 || i == 7 || i == 13 || i == 15) begin
        q4.push_back('{d: ew[k], last: (k == 3), cyc: 32'(ac + 1)});
        k++;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic stall_after_first();
    int g = 0;
    while (!win_valid && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) chk("stall_wait_timeout", 64'(g), 64'h0);
    win_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    win_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pix_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q4.delete();
    seen = 1'b0;
    chk("rst_win_valid", 64'(win_valid), 64'h0);
    chk("rst_win_last", 64'(win_last), 64'h0);
    chk("rst_win_data", {32'h0, win_data[0], win_data[1], win_data[2], win_data[3]}, 64'h0);
    chk("rst_pix_ready", 64'(pix_ready), 64'h1);
  endtask

  task automatic drain();
    int g = 0;
    while (q4.size() != 0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain_empty", 64'(q4.size()), 64'h0);
  endtask

  logic signed [DW-1:0] sv2 [4] = '{-8'sd128, 8'sd127, -8'sd1, 8'sd0};

  initial begin
    int ac, w;
    rst = 1'b1; pix_valid = 1'b0; pix_data = '0; win_ready = 1'b1;
    pv2 = 1'b0; pd2 = '0; wr2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Plain frame, downstream always ready
    send_frame4(0, exp_a, 1'b0);
    drain();

    // Downstream stalls three cycles after the first window
    fork
      send_frame4(0, exp_a, 1'b0);
      stall_after_first();
    join
    drain();

    // Two frames back to back; no stalls expected
    stall_cnt = 0;
    send_frame4(0, exp_a, 1'b0);
    send_frame4(0, exp_a, 1'b0);
    chk("b2b_no_stall", 64'(stall_cnt), 64'h0);
    drain();

    // Randomly gapped input
    send_frame4(0, exp_a, 1'b1);
    drain();

    // Reset while a window is pending
    win_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      put_px(DW'(i), ac, w);
      if (i == 5) q4.push_back('{d: exp_a[0], last: 1'b0, cyc: 32'(ac + 1)});
    end
    pix_valid = 1'b0;
    @(posedge clk); #1;
    do_reset();
    win_ready = 1'b1;

    // Reset after pixel 6 of a frame, then a fresh frame
    for (int i = 0; i < 7; i++) begin
      put_px(DW'(i), ac, w);
      if (i == 5) q4.push_back('{d: exp_a[0], last: 1'b0, cyc: 32'(ac + 1)});
    end
    do_reset();
    send_frame4(100, exp_b, 1'b0);
    drain();

    // Signed pass-through on a 2x2 frame
    for (int i = 0; i < 4; i++) begin
      pv2 = 1'b1;
      pd2 = sv2[i];
      @(negedge clk);
      chk("s2_pix_ready", 64'(pr2), 64'h1);
      @(posedge clk); #1;
    end
    pv2 = 1'b0;
    @(negedge clk);
    chk("s2_win_valid", 64'(wv2), 64'h1);
    chk("s2_win_data", {32'h0, wd2[0], wd2[1], wd2[2], wd2[3]}, 64'h807FFF00);
    chk("s2_win_last", 64'(wl2), 64'h1);
    @(negedge clk);
    chk("s2_win_cleared", 64'(wv2), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pool_window_gen.md
POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 8: pixels per row (even, >=2).
REQ-003 SHALL have parameter IMG_HEIGHT, default 8: rows per frame (even, >=2).
REQ-004 SHALL have parameter POOL_SIZE, default 4: window elements (fixed 2x2; other values unsupported).
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 pix_valid  input  1  pixel on pix_data is valid.
REQ-008 pix_ready  output  1  block accepts pixel this cycle.
REQ-009 pix_data  input  DATA_WIDTH  signed pixel in raster order (row-major, left to right).
REQ-010 win_valid  output  1  window on win_data is valid.
REQ-011 win_ready  input  1  downstream max-pooling stage accepts window.
REQ-012 win_data  output  POOL_SIZE x DATA_WIDTH  signed unpacked array: [0]=top-left, [1]=top-right, [2]=bottom-left, [3]=bottom-right.
REQ-013 win_last  output  1  qualifies the final window of the frame; valid only with win_valid.

Function
REQ-014 A pixel SHALL be accepted on a rising edge where pix_valid && pix_ready; a window SHALL transfer where win_valid && win_ready.
REQ-015 Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) SHALL advance only on pixel acceptance; col wraps to 0 and increments row; row wraps to 0 after pixel (IMG_HEIGHT-1, IMG_WIDTH-1), starting a new frame with no idle cycle.
REQ-016 State machine SHALL have states FILL (even row) and PAIR (odd row); FILL->PAIR on acceptance at col=IMG_WIDTH-1 of an even row; PAIR->FILL on acceptance at col=IMG_WIDTH-1 of an odd row.
REQ-017 In FILL, each accepted pixel SHALL be written to line buffer entry [col] (IMG_WIDTH x DATA_WIDTH).
REQ-018 In PAIR at even col, the accepted pixel SHALL be held in a left register; line buffer SHALL not be modified in PAIR.
REQ-019 In PAIR at odd col, acceptance SHALL load the output register with {lb[col-1], lb[col], left, pix_data} and set win_valid on the next cycle (latency 1 cycle from completing pixel).
REQ-020 win_last SHALL be loaded 1 together with a window when that window's completing pixel is at row=IMG_HEIGHT-1, col=IMG_WIDTH-1, else 0.
REQ-021 win_data and win_last SHALL remain stable while win_valid && !win_ready.
REQ-022 pix_ready SHALL equal !win_valid || win_ready (combinational); a window transfer and a new completing pixel in the same cycle SHALL reload the output register with win_valid staying 1.
REQ-023 win_valid SHALL clear on transfer when no new window is loaded that cycle.
REQ-024 Values SHALL pass unmodified (no arithmetic, sign preserved); exactly (IMG_WIDTH/2)*(IMG_HEIGHT/2) windows per frame.
REQ-025 pix_data SHALL be ignored when pix_valid=0 or pix_ready=0.

Reset
REQ-026 On rst=1 at a rising edge: win_valid=0, win_last=0, win_data all 0, col=0, row=0, state=FILL, left register=0; pix_ready SHALL read 1 in the following cycle.
REQ-027 Line buffer contents need not be reset; they SHALL never be output before being rewritten in the current frame.
REQ-028 Reset asserted mid-frame SHALL discard any pending window and partial rows; the next accepted pixel is frame pixel (0,0).

Verification
REQ-029 IMG_WIDTH=4, IMG_HEIGHT=4, pixels 0..15 streamed, win_ready=1 -> windows {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}; win_last=1 only on the 4th; each win_valid one cycle after pixels 5, 7, 13, 15.
REQ-030 Same stream, win_ready=0 for 3 cycles after first window -> win_data holds {0,1,4,5}, pix_ready=0 while held; no pixel lost; remaining windows unchanged.
REQ-031 Signed values: row0 = -128,127; row1 = -1,0 (width 2, height 2) -> window {-128,127,-1,0}, win_last=1.
REQ-032 Two back-to-back 4x4 frames with pix_valid=1 every cycle and win_ready=1 -> 8 windows, win_last on 4th and 8th, no pixel stall.
REQ-033 rst pulsed after pixel 6 of frame, then pixels 100..115 -> first window {100,101,104,105}; no window from pre-reset data.
REQ-034 pix_valid toggled randomly (1 of 2 cycles) -> window contents identical to REQ-029.
